// File: rtl/hpdcache_victim_alloc.sv
// hpdcache_victim_alloc
//
// Refill-allocation stage in front of the HPDcache pseudo-LRU replacement
// block. For each miss-refill request it reads the directory of the target set,
// shows the per-way state to the PLRU victim selector and latches the chosen
// way. If that way holds a valid dirty line, it runs the write-back eviction
// handshake. It then commits the replacement to the PLRU and returns the
// allocated way to the requester.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   req_*                   allocation request (valid/ready, target set)
//   dir_rd_*                directory read strobe and set
//   dir_*_i                 directory state/tags, one cycle after dir_rd_o
//   plru_dir_*_o            directory state forwarded to the PLRU selector
//   plru_victim_way_i       one-hot (or zero) victim chosen by the PLRU
//   plru_repl_*             single-cycle replacement commit to the PLRU
//   evict_*                 dirty-line eviction handshake and payload
//   rsp_*                   allocation response (way, evicted flag)

module hpdcache_victim_alloc #(
    parameter  int unsigned SETS      = 64,
    parameter  int unsigned WAYS      = 4,
    parameter  int unsigned TAG_WIDTH = 20,
    localparam int unsigned SET_W     = $clog2(SETS)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [SET_W-1:0]          req_set_i,
    output logic                      dir_rd_o,
    output logic [SET_W-1:0]          dir_rd_set_o,
    input  logic [WAYS-1:0]           dir_valid_i,
    input  logic [WAYS-1:0]           dir_wb_i,
    input  logic [WAYS-1:0]           dir_dirty_i,
    input  logic [WAYS*TAG_WIDTH-1:0] dir_tags_i,
    output logic [WAYS-1:0]           plru_dir_valid_o,
    output logic [WAYS-1:0]           plru_dir_wb_o,
    output logic [WAYS-1:0]           plru_dir_dirty_o,
    input  logic [WAYS-1:0]           plru_victim_way_i,
    output logic                      plru_repl_o,
    output logic [SET_W-1:0]          plru_repl_set_o,
    output logic [WAYS-1:0]           plru_repl_way_o,
    output logic                      evict_valid_o,
    input  logic                      evict_ready_i,
    output logic [SET_W-1:0]          evict_set_o,
    output logic [TAG_WIDTH-1:0]      evict_tag_o,
    output logic [WAYS-1:0]           evict_way_o,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [WAYS-1:0]           rsp_way_o,
    output logic                      rsp_evicted_o
);

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        EVICT,
        RESP
    } state_e;

    state_e                 state_q, state_d;
    logic [SET_W-1:0]       set_q, set_d;
    logic [WAYS-1:0]        way_q, way_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
    logic                   evicted_q, evicted_d;
    // High during the first RESP cycle only, so the PLRU commit cannot repeat
    // while the response is stalled.
    logic                   replFirst_q, replFirst_d;

    logic [TAG_WIDTH-1:0]   victimTag;
    logic                   victimDirty;

    // Pick the victim's tag with an AND-OR mux on the one-hot way. Also work
    // out whether the victim holds a valid dirty line that must be written back.
    always_comb begin
        victimTag = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            victimTag = victimTag
                      | ({TAG_WIDTH{plru_victim_way_i[w]}} & dir_tags_i[w*TAG_WIDTH +: TAG_WIDTH]);
        end
        victimDirty = |(plru_victim_way_i & dir_valid_i & dir_dirty_i);
    end

    // State and latched payload registers. Reset drops any eviction or response
    // that is still in progress.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            set_q       <= '0;
            way_q       <= '0;
            tag_q       <= '0;
            evicted_q   <= 1'b0;
            replFirst_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            set_q       <= set_d;
            way_q       <= way_d;
            tag_q       <= tag_d;
            evicted_q   <= evicted_d;
            replFirst_q <= replFirst_d;
        end
    end

    // Next-state and output logic. Every output is forced to zero outside the
    // state that owns it, so idle interfaces never show stale payload.
    always_comb begin
        state_d          = state_q;
        set_d            = set_q;
        way_d            = way_q;
        tag_d            = tag_q;
        evicted_d        = evicted_q;
        replFirst_d      = 1'b0;

        req_ready_o      = 1'b0;
        dir_rd_o         = 1'b0;
        dir_rd_set_o     = '0;
        plru_dir_valid_o = '0;
        plru_dir_wb_o    = '0;
        plru_dir_dirty_o = '0;
        plru_repl_o      = 1'b0;
        plru_repl_set_o  = '0;
        plru_repl_way_o  = '0;
        evict_valid_o    = 1'b0;
        evict_set_o      = '0;
        evict_tag_o      = '0;
        evict_way_o      = '0;
        rsp_valid_o      = 1'b0;
        rsp_way_o        = '0;
        rsp_evicted_o    = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    dir_rd_o     = 1'b1;
                    dir_rd_set_o = req_set_i;
                    set_d        = req_set_i;
                    state_d      = SELECT;
                end
            end
            SELECT: begin
                plru_dir_valid_o = dir_valid_i;
                plru_dir_wb_o    = dir_wb_i;
                plru_dir_dirty_o = dir_dirty_i;
                // The PLRU is addressed through its repl set port while selecting.
                plru_repl_set_o  = set_q;
                way_d            = plru_victim_way_i;
                tag_d            = victimTag;
                evicted_d        = 1'b0;
                replFirst_d      = 1'b1;
                if ((plru_victim_way_i != '0) && victimDirty) begin
                    replFirst_d = 1'b0;
                    state_d     = EVICT;
                end else begin
                    state_d = RESP;
                end
            end
            EVICT: begin
                evict_valid_o = 1'b1;
                evict_set_o   = set_q;
                evict_tag_o   = tag_q;
                evict_way_o   = way_q;
                if (evict_ready_i) begin
                    evicted_d   = 1'b1;
                    replFirst_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                rsp_valid_o   = 1'b1;
                rsp_way_o     = way_q;
                rsp_evicted_o = evicted_q;
                if (replFirst_q && (way_q != '0)) begin
                    plru_repl_o     = 1'b1;
                    plru_repl_set_o = set_q;
                    plru_repl_way_o = way_q;
                end
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A victim with several bits set breaks the PLRU protocol. It is flagged
    // here and never repaired in logic.
    victim_onehot_a : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (state_q == SELECT) |-> $onehot0(plru_victim_way_i)
    );

endmodule

// File: tb/tb_hpdcache_victim_alloc.sv
// tb_hpdcache_victim_alloc
//
// Directed bench for hpdcache_victim_alloc: clean allocations, unused victims,
// dirty eviction with back-pressure, zero victims, response stalls and reset
// in the middle of an eviction. All expected values are written by hand.

module tb_hpdcache_victim_alloc;

    localparam int unsigned SETS      = 64;
    localparam int unsigned WAYS      = 4;
    localparam int unsigned TAG_WIDTH = 20;
    localparam int unsigned SET_W     = $clog2(SETS);

    logic                      clk_i = 1'b0;
    logic                      rst_ni = 1'b0;
    logic                      req_valid_i = 1'b0;
    logic                      req_ready_o;
    logic [SET_W-1:0]          req_set_i = '0;
    logic                      dir_rd_o;
    logic [SET_W-1:0]          dir_rd_set_o;
    logic [WAYS-1:0]           dir_valid_i = '0;
    logic [WAYS-1:0]           dir_wb_i = '0;
    logic [WAYS-1:0]           dir_dirty_i = '0;
    logic [WAYS*TAG_WIDTH-1:0] dir_tags_i = '0;
    logic [WAYS-1:0]           plru_dir_valid_o;
    logic [WAYS-1:0]           plru_dir_wb_o;
    logic [WAYS-1:0]           plru_dir_dirty_o;
    logic [WAYS-1:0]           plru_victim_way_i = '0;
    logic                      plru_repl_o;
    logic [SET_W-1:0]          plru_repl_set_o;
    logic [WAYS-1:0]           plru_repl_way_o;
    logic                      evict_valid_o;
    logic                      evict_ready_i = 1'b0;
    logic [SET_W-1:0]          evict_set_o;
    logic [TAG_WIDTH-1:0]      evict_tag_o;
    logic [WAYS-1:0]           evict_way_o;
    logic                      rsp_valid_o;
    logic                      rsp_ready_i = 1'b0;
    logic [WAYS-1:0]           rsp_way_o;
    logic                      rsp_evicted_o;

    int checks = 0;
    int failures = 0;
    int replCount = 0;

    hpdcache_victim_alloc #(
        .SETS      (SETS),
        .WAYS      (WAYS),
        .TAG_WIDTH (TAG_WIDTH)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .req_set_i         (req_set_i),
        .dir_rd_o          (dir_rd_o),
        .dir_rd_set_o      (dir_rd_set_o),
        .dir_valid_i       (dir_valid_i),
        .dir_wb_i          (dir_wb_i),
        .dir_dirty_i       (dir_dirty_i),
        .dir_tags_i        (dir_tags_i),
        .plru_dir_valid_o  (plru_dir_valid_o),
        .plru_dir_wb_o     (plru_dir_wb_o),
        .plru_dir_dirty_o  (plru_dir_dirty_o),
        .plru_victim_way_i (plru_victim_way_i),
        .plru_repl_o       (plru_repl_o),
        .plru_repl_set_o   (plru_repl_set_o),
        .plru_repl_way_o   (plru_repl_way_o),
        .evict_valid_o     (evict_valid_o),
        .evict_ready_i     (evict_ready_i),
        .evict_set_o       (evict_set_o),
        .evict_tag_o       (evict_tag_o),
        .evict_way_o       (evict_way_o),
        .rsp_valid_o       (rsp_valid_o),
        .rsp_ready_i       (rsp_ready_i),
        .rsp_way_o         (rsp_way_o),
        .rsp_evicted_o     (rsp_evicted_o)
    );

    // 10 ns clock.
    always #5 clk_i = ~clk_i;

    // Count cycles in which the PLRU commit is high, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (plru_repl_o === 1'b1) begin
            replCount++;
        end
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: count it, and report a mismatch with the tag and both values.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Move 1 ns past the next rising edge, which is where inputs are driven.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive the directory contents and the PLRU answer for the SELECT cycle.
    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] wb, input logic [3:0] dirty,
                                 input logic [3:0] victim, input logic [TAG_WIDTH-1:0] tag3);
        dir_valid_i       = valid;
        dir_wb_i          = wb;
        dir_dirty_i       = dirty;
        plru_victim_way_i = victim;
        dir_tags_i        = {tag3, 20'hAAAAA, 20'h55555, 20'h0F0F0};
    endtask

    // Present a request for one cycle and check the directory read strobe.
    task automatic sendRequest(input logic [SET_W-1:0] set, input string tag);
        req_valid_i = 1'b1;
        req_set_i   = set;
        #1;
        checkOutput({tag, "_dir_rd"}, 32'(dir_rd_o), 32'd1);
        checkOutput({tag, "_dir_rd_set"}, 32'(dir_rd_set_o), 32'(set));
        tick();
        req_valid_i = 1'b0;
    endtask

    initial begin
        int replBefore;

        // Reset state.
        #2;
        checkOutput("rst_req_ready", 32'(req_ready_o), 32'd1);
        checkOutput("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("rst_evict_valid", 32'(evict_valid_o), 32'd0);
        checkOutput("rst_repl", 32'(plru_repl_o), 32'd0);
        checkOutput("rst_dir_rd", 32'(dir_rd_o), 32'd0);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        // Test 1: set 5 with an empty directory; the PLRU picks way 0.
        sendRequest(6'd5, "t1");
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0001, 20'h00000);
        #1;
        checkOutput("t1_sel_repl_set", 32'(plru_repl_set_o), 32'd5);
        checkOutput("t1_sel_dir_valid", 32'(plru_dir_valid_o), 32'd0);
        tick();
        rsp_ready_i = 1'b1;
        #1;
        checkOutput("t1_rsp_valid", 32'(rsp_valid_o), 32'd1);
        checkOutput("t1_rsp_way", 32'(rsp_way_o), 32'h1);
        checkOutput("t1_repl", 32'(plru_repl_o), 32'd1);
        checkOutput("t1_repl_set", 32'(plru_repl_set_o), 32'd5);
        checkOutput("t1_repl_way", 32'(plru_repl_way_o), 32'h1);
        checkOutput("t1_evicted", 32'(rsp_evicted_o), 32'd0);
        tick();
        rsp_ready_i = 1'b0;
        checkOutput("t1_idle_ready", 32'(req_ready_o), 32'd1);
        checkOutput("t1_idle_rsp_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("t1_repl_count", 32'(replCount), 32'd1);

        // Test 2: way 2 is clean and chosen, so no eviction happens.
        sendRequest(6'd12, "t2");
        applyStimulus(4'b1111, 4'b1111, 4'b1011, 4'b0100, 20'h11111);
        #1;
        checkOutput("t2_sel_dirty", 32'(plru_dir_dirty_o), 32'hB);
        checkOutput("t2_sel_wb", 32'(plru_dir_wb_o), 32'hF);
        tick();
        rsp_ready_i = 1'b1;
        #1;
        checkOutput("t2_evict_valid", 32'(evict_valid_o), 32'd0);
        checkOutput("t2_rsp_valid", 32'(rsp_valid_o), 32'd1);
        checkOutput("t2_rsp_way", 32'(rsp_way_o), 32'h4);
        checkOutput("t2_repl", 32'(plru_repl_o), 32'd1);
        tick();
        rsp_ready_i = 1'b0;

        // Test 3: dirty way 3 is evicted while the eviction ready is held off.
        sendRequest(6'd33, "t3");
        applyStimulus(4'b1111, 4'b1111, 4'b1111, 4'b1000, 20'h12345);
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("t3_evict_valid", 32'(evict_valid_o), 32'd1);
            checkOutput("t3_evict_tag", 32'(evict_tag_o), 32'h12345);
            checkOutput("t3_evict_way", 32'(evict_way_o), 32'h8);
            checkOutput("t3_evict_set", 32'(evict_set_o), 32'd33);
            checkOutput("t3_no_rsp", 32'(rsp_valid_o), 32'd0);
            checkOutput("t3_no_repl", 32'(plru_repl_o), 32'd0);
            tick();
        end
        evict_ready_i = 1'b1;
        tick();
        evict_ready_i = 1'b0;
        rsp_ready_i   = 1'b1;
        #1;
        checkOutput("t3_rsp_valid", 32'(rsp_valid_o), 32'd1);
        checkOutput("t3_repl", 32'(plru_repl_o), 32'd1);
        checkOutput("t3_repl_way", 32'(plru_repl_way_o), 32'h8);
        checkOutput("t3_repl_set", 32'(plru_repl_set_o), 32'd33);
        checkOutput("t3_evicted", 32'(rsp_evicted_o), 32'd1);
        checkOutput("t3_evict_off", 32'(evict_valid_o), 32'd0);
        tick();
        rsp_ready_i = 1'b0;

        // Test 4: the PLRU offers no way, so there is no commit.
        replBefore = replCount;
        sendRequest(6'd7, "t4");
        applyStimulus(4'b1111, 4'b0000, 4'b1111, 4'b0000, 20'h22222);
        tick();
        rsp_ready_i = 1'b1;
        #1;
        checkOutput("t4_rsp_valid", 32'(rsp_valid_o), 32'd1);
        checkOutput("t4_rsp_way", 32'(rsp_way_o), 32'h0);
        checkOutput("t4_repl", 32'(plru_repl_o), 32'd0);
        checkOutput("t4_evict_valid", 32'(evict_valid_o), 32'd0);
        tick();
        rsp_ready_i = 1'b0;
        checkOutput("t4_repl_count", 32'(replCount - replBefore), 32'd0);

        // Test 5: a stalled response gives one commit, and the next request
        // waits until the response handshake has completed.
        replBefore = replCount;
        sendRequest(6'd9, "t5");
        applyStimulus(4'b1111, 4'b0000, 4'b0000, 4'b0010, 20'h33333);
        tick();
        req_valid_i = 1'b1;
        req_set_i   = 6'd17;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("t5_stall_rsp_valid", 32'(rsp_valid_o), 32'd1);
            checkOutput("t5_stall_rsp_way", 32'(rsp_way_o), 32'h2);
            checkOutput("t5_stall_req_ready", 32'(req_ready_o), 32'd0);
            checkOutput("t5_stall_dir_rd", 32'(dir_rd_o), 32'd0);
            tick();
        end
        rsp_ready_i = 1'b1;
        #1;
        checkOutput("t5_hs_req_ready", 32'(req_ready_o), 32'd0);
        tick();
        rsp_ready_i = 1'b0;
        checkOutput("t5_repl_count", 32'(replCount - replBefore), 32'd1);
        checkOutput("t5_next_req_ready", 32'(req_ready_o), 32'd1);
        checkOutput("t5_next_dir_rd", 32'(dir_rd_o), 32'd1);
        checkOutput("t5_next_dir_set", 32'(dir_rd_set_o), 32'd17);
        tick();
        req_valid_i = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0001, 20'h00000);
        tick();
        rsp_ready_i = 1'b1;
        #1;
        checkOutput("t5b_rsp_way", 32'(rsp_way_o), 32'h1);
        checkOutput("t5b_repl_set", 32'(plru_repl_set_o), 32'd17);
        tick();
        rsp_ready_i = 1'b0;

        // Test 6: reset during an eviction drops it without a PLRU commit.
        replBefore = replCount;
        sendRequest(6'd40, "t6");
        applyStimulus(4'b1111, 4'b1111, 4'b1111, 4'b0001, 20'h44444);
        tick();
        #1;
        checkOutput("t6_evict_valid", 32'(evict_valid_o), 32'd1);
        rst_ni        = 1'b0;
        evict_ready_i = 1'b1;
        rsp_ready_i   = 1'b1;
        #1;
        checkOutput("t6_rst_evict_off", 32'(evict_valid_o), 32'd0);
        checkOutput("t6_rst_req_ready", 32'(req_ready_o), 32'd1);
        tick();
        rst_ni = 1'b1;
        #1;
        checkOutput("t6_after_evict_off", 32'(evict_valid_o), 32'd0);
        checkOutput("t6_after_req_ready", 32'(req_ready_o), 32'd1);
        tick();
        tick();
        checkOutput("t6_rsp_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("t6_repl_count", 32'(replCount - replBefore), 32'd0);
        evict_ready_i = 1'b0;
        rsp_ready_i   = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hpdcache_victim_alloc.md
# hpdcache_victim_alloc

Refill-allocation stage feeding the HPDcache pseudo-LRU replacement block. For each miss-refill request it:
- reads the directory of the target set and presents the per-way state to the PLRU victim selector;
- latches the selected victim way and runs the write-back eviction handshake if that way is dirty;
- commits the replacement to the PLRU through its `repl` interface, then returns the allocated way to the refill requester.

## Interface
- `SETS`, 64, number of cache sets (power of two, ≥2)
- `WAYS`, 4, number of ways (≥2)
- `TAG_WIDTH`, 20, tag width in bits
- `clk_i` in 1: clock; all state updates on rising edge
- `rst_ni` in 1: reset; asynchronous, active-low
- `req_valid_i` in 1, `req_ready_o` out 1: allocation request handshake
- `req_set_i` in $clog2(SETS): target set
- `dir_rd_o` out 1, `dir_rd_set_o` out $clog2(SETS): directory read strobe and set
- `dir_valid_i`, `dir_wb_i`, `dir_dirty_i` in WAYS: directory state, valid exactly one cycle after `dir_rd_o`
- `dir_tags_i` in WAYS*TAG_WIDTH: per-way tags, same timing; way w at bits [w*TAG_WIDTH +: TAG_WIDTH]
- `plru_dir_valid_o`, `plru_dir_wb_o`, `plru_dir_dirty_o` out WAYS: to PLRU selection inputs
- `plru_victim_way_i` in WAYS: one-hot or zero victim from PLRU
- `plru_repl_o` out 1, `plru_repl_set_o` out $clog2(SETS), `plru_repl_way_o` out WAYS: PLRU replacement commit
- `evict_valid_o` out 1, `evict_ready_i` in 1: dirty-line eviction handshake
- `evict_set_o` out $clog2(SETS), `evict_tag_o` out TAG_WIDTH, `evict_way_o` out WAYS: eviction payload
- `rsp_valid_o` out 1, `rsp_ready_i` in 1: allocation response handshake
- `rsp_way_o` out WAYS: allocated way, one-hot; all-zero means no allocatable way
- `rsp_evicted_o` out 1: a dirty line was written back for this allocation

## Operation
- FSM states: IDLE, SELECT, EVICT, RESP.
- **IDLE**
  - `req_ready_o`=1.
  - On `req_valid_i`: `dir_rd_o`=1 and `dir_rd_set_o`=`req_set_i`, both combinational in the same cycle. Latch the set; go to SELECT.
- **SELECT** (one cycle)
  - `plru_dir_*_o` = `dir_*_i` combinationally; the PLRU is read with `repl_set_i` = latched set.
  - Latch `plru_victim_way_i`, the victim's tag (AND-OR mux on the one-hot way), and the victim's `valid & dirty` bit.
  - Zero victim → RESP with `rsp_way_o`=0 and no PLRU commit.
  - Victim valid and dirty → EVICT.
  - Otherwise → RESP.
- **EVICT**
  - `evict_valid_o`=1 with stable set, tag and way until `evict_ready_i`.
  - On the handshake → RESP with `rsp_evicted_o`=1.
- **RESP**
  - `rsp_valid_o`=1 with stable payload until `rsp_ready_i`, then → IDLE.
  - `plru_repl_o`=1 only in the first cycle of RESP and only for a nonzero victim; `plru_repl_set_o`/`plru_repl_way_o` carry the latched set and way.
- Outside SELECT, `plru_dir_*_o` = 0. Outside EVICT, the `evict_*` payload outputs = 0.
- One request in flight; no pipelining across requests.
- `plru_victim_way_i` with more than one bit set is a protocol error (assertion). It is never corrected in RTL.

## Timing
- Reset values: state IDLE. `req_ready_o`=1 (the only output that is 1 during reset); all other outputs 0, all latched payloads 0.
- Request accepted at cycle T: `dir_rd_o` at T, SELECT at T+1.
- Clean or unused victim: `rsp_valid_o` and `plru_repl_o` at T+2.
- Dirty victim: `evict_valid_o` from T+2; `evict_ready_i` seen at cycle E → RESP at E+1.
- Ready already high when valid rises: the handshake completes that cycle. A response accepted at cycle R gives `req_ready_o`=1 at R+1; back-to-back requests are 3 cycles apart minimum.
- `plru_repl_o` is never high for more than one cycle per request, even if `rsp_ready_i` stalls.
- Reset asserted mid-operation (any state): immediate return to IDLE. An in-progress eviction or response is dropped and no PLRU commit is issued.

## Test plan
- Reset release, then set 5 with `dir_valid`=4'b0000 → PLRU picks 4'b0001; at T+2 `rsp_way_o`=4'b0001, `plru_repl_o`=1 for one cycle with set 5; `rsp_evicted_o`=0.
- All valid, way 2 clean, others dirty with wb=1, PLRU returns 4'b0100 → no `evict_valid_o`; response way 4'b0100 at T+2.
- All valid, dirty, wb=1, PLRU returns 4'b1000, tag3=0x12345 → `evict_valid_o` at T+2 with `evict_tag_o`=0x12345. Hold `evict_ready_i`=0 for 4 cycles: payload stable. Ready at E → `rsp_valid_o` and `plru_repl_o` at E+1, `rsp_evicted_o`=1.
- All valid, dirty, wb=0, PLRU returns 0 → `rsp_way_o`=0 at T+2; `plru_repl_o` stays 0.
- `rsp_ready_i`=0 for 3 cycles → `plru_repl_o` pulses once, `rsp_valid_o` holds; a second request is not accepted until the cycle after the response handshake.
- `rst_ni` asserted during EVICT → next cycle `evict_valid_o`=0, `req_ready_o`=1, no `plru_repl_o` ever issued.
